// File: rtl/axi_rdata_bram_packer.sv
// Packs PACK consecutive AXI read beats into one BRAM word and writes TOTAL_NUM beats per stage from address 0.
// Optional: define AXI_RPACK_PARTIAL_FLUSH_EN to write out a partially filled word when a stage is aborted.
module axi_rdata_bram_packer #(
    parameter int AXI_DW    = 32,
    parameter int PACK      = 2,
    parameter int BRAM_AW   = 14,
    parameter int TOTAL_NUM = 1536
) (
    input  logic                   axi_ACLK,
    input  logic                   axi_ARESET,
    input  logic                   stage_start,
    input  logic [AXI_DW-1:0]      axi_RDATA,
    input  logic                   axi_RLAST,
    input  logic                   axi_SHAKE,
    output logic                   bram_wea,
    output logic [BRAM_AW-1:0]     bram_addra,
    output logic [AXI_DW*PACK-1:0] bram_dina,
    output logic                   bram_wdone,
    output logic                   err_overrun,
    output logic                   err_rlast
);

    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int BEAT_W = (TOTAL_NUM > 1) ? $clog2(TOTAL_NUM) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TOTAL_NUM - 1);

    generate
        if (PACK < 1 || TOTAL_NUM < 1 || (TOTAL_NUM % PACK) != 0 ||
            longint'(TOTAL_NUM / PACK) > (64'd1 << BRAM_AW)) begin : g_bad_cfg
            $error("axi_rdata_bram_packer: illegal PACK/TOTAL_NUM/BRAM_AW combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        state_q;
    logic                          start_q;
    logic [BEAT_W-1:0]             beat_cnt_q;
    logic [LANE_W-1:0]             lane_q;
    logic [BRAM_AW-1:0]            word_cnt_q;
    logic [PACK-1:0][AXI_DW-1:0]   pack_q;
    logic [PACK-1:0][AXI_DW-1:0]   pack_d;

    // Pack register with the current beat merged in; feeds both the lane update and the full-word write.
    always_comb begin
        pack_d         = pack_q;
        pack_d[lane_q] = axi_RDATA;
    end

    always_ff @(posedge axi_ACLK or posedge axi_ARESET) begin
        if (axi_ARESET) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            beat_cnt_q  <= '0;
            lane_q      <= '0;
            word_cnt_q  <= '0;
            pack_q      <= '0;
            bram_wea    <= 1'b0;
            bram_addra  <= '0;
            bram_dina   <= '0;
            bram_wdone  <= 1'b0;
            err_overrun <= 1'b0;
            err_rlast   <= 1'b0;
        end else begin
            start_q  <= stage_start;
            bram_wea <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A beat coincident with the start edge is dropped: counting begins next cycle.
                    if (stage_start && !start_q) begin
                        beat_cnt_q  <= '0;
                        lane_q      <= '0;
                        word_cnt_q  <= '0;
                        pack_q      <= '0;
                        bram_wdone  <= 1'b0;
                        err_overrun <= 1'b0;
                        err_rlast   <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (!stage_start) begin
`ifdef AXI_RPACK_PARTIAL_FLUSH_EN
                        if (lane_q != '0) begin
                            bram_wea   <= 1'b1;
                            bram_addra <= word_cnt_q;
                            bram_dina  <= pack_q;
                        end
`endif
                        lane_q  <= '0;
                        pack_q  <= '0;
                        state_q <= IDLE;
                    end else if (axi_SHAKE) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (lane_q == LAST_LANE) begin
                            bram_wea   <= 1'b1;
                            bram_addra <= word_cnt_q;
                            bram_dina  <= pack_d;
                            word_cnt_q <= word_cnt_q + 1'b1;
                            lane_q     <= '0;
                            pack_q     <= '0;
                        end else begin
                            pack_q <= pack_d;
                            lane_q <= lane_q + 1'b1;
                        end
                        // TOTAL_NUM is a multiple of PACK, so this edge also issues the final write.
                        if (beat_cnt_q == LAST_BEAT) begin
                            bram_wdone <= 1'b1;
                            err_rlast  <= !axi_RLAST;
                            state_q    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (axi_SHAKE) err_overrun <= 1'b1;
                    if (!stage_start) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rdata_bram_packer.sv
// Directed bench for axi_rdata_bram_packer at default parameters (PACK=2, TOTAL_NUM=1536).
module tb_axi_rdata_bram_packer;

    localparam int AXI_DW  = 32;
    localparam int PACK    = 2;
    localparam int BRAM_AW = 14;
    localparam int TOTAL   = 1536;
    localparam int WORDS   = TOTAL / PACK;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [AXI_DW-1:0]      rdata;
    logic                   rlast;
    logic                   shake;
    logic                   wea;
    logic [BRAM_AW-1:0]     addra;
    logic [AXI_DW*PACK-1:0] dina;
    logic                   wdone;
    logic                   ovr;
    logic                   rle;

    int checks = 0;
    int errors = 0;
    int nwr    = 0;

    axi_rdata_bram_packer #(
        .AXI_DW(AXI_DW), .PACK(PACK), .BRAM_AW(BRAM_AW), .TOTAL_NUM(TOTAL)
    ) dut (
        .axi_ACLK(clk), .axi_ARESET(rst), .stage_start(start),
        .axi_RDATA(rdata), .axi_RLAST(rlast), .axi_SHAKE(shake),
        .bram_wea(wea), .bram_addra(addra), .bram_dina(dina),
        .bram_wdone(wdone), .err_overrun(ovr), .err_rlast(rle)
    );

    always #5 clk = ~clk;

    // Drives n beats (RDATA = index), checking every cycle's write strobe, data and flags.
    task automatic run_beats(input int n, input int gap_max, input bit drop_rlast);
        for (int i = 0; i < n; i++) begin
            int g;
            logic exp_w, exp_done, exp_ovr, exp_rle;
            logic [63:0] exp_d;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int k = 0; k < g; k++) begin
                @(posedge clk); #1;
                checks++;
                if (wea !== 1'b0) begin errors++; $display("FAIL gap_wea beat=%0d got=%b want=0", i, wea); end
            end
            shake = 1'b1;
            rdata = i;
            rlast = (i % 16 == 15) && !(drop_rlast && i == TOTAL - 1);
            @(posedge clk); #1;
            shake = 1'b0;
            rlast = 1'b0;
            exp_w    = (i % 2 == 1) && (i < TOTAL);
            exp_done = (i >= TOTAL - 1);
            exp_ovr  = (i >= TOTAL);
            exp_rle  = drop_rlast && (i >= TOTAL - 1);
            checks++;
            if (wea !== exp_w) begin errors++; $display("FAIL wea beat=%0d got=%b want=%b", i, wea, exp_w); end
            if (exp_w) begin
                nwr++;
                exp_d = {32'(i), 32'(i - 1)};
                checks++;
                if (addra !== BRAM_AW'(i / 2)) begin errors++; $display("FAIL addra beat=%0d got=%0d want=%0d", i, addra, i / 2); end
                checks++;
                if (dina !== exp_d) begin errors++; $display("FAIL dina beat=%0d got=%h want=%h", i, dina, exp_d); end
            end
            checks++;
            if (wdone !== exp_done) begin errors++; $display("FAIL wdone beat=%0d got=%b want=%b", i, wdone, exp_done); end
            checks++;
            if (ovr !== exp_ovr) begin errors++; $display("FAIL err_overrun beat=%0d got=%b want=%b", i, ovr, exp_ovr); end
            checks++;
            if (rle !== exp_rle) begin errors++; $display("FAIL err_rlast beat=%0d got=%b want=%b", i, rle, exp_rle); end
        end
    endtask

    task automatic do_start(input bit bogus);
        start = 1'b1;
        if (bogus) begin shake = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b1; end
        @(posedge clk); #1;
        shake = 1'b0;
        rlast = 1'b0;
        checks++;
        if ({wea, wdone, ovr, rle} !== 4'b0000)
            begin errors++; $display("FAIL start_clear got=%b want=0000", {wea, wdone, ovr, rle}); end
    endtask

    task automatic do_stop(input logic [2:0] exp_flags, input string name);
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (wea !== 1'b0) begin errors++; $display("FAIL %s_stop_wea got=%b want=0", name, wea); end
        @(posedge clk); #1;
        checks++;
        if ({wdone, ovr, rle} !== exp_flags)
            begin errors++; $display("FAIL %s_flags got=%b want=%b", name, {wdone, ovr, rle}, exp_flags); end
        checks++;
        if (nwr !== WORDS) begin errors++; $display("FAIL %s_writes got=%0d want=%0d", name, nwr, WORDS); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; shake = 1'b0; rlast = 1'b0; rdata = '0;
        #12;
        checks++;
        if ({wea, addra, dina, wdone, ovr, rle} !== '0)
            begin errors++; $display("FAIL reset_outputs got=%b/%h/%h/%b%b%b want=0", wea, addra, dina, wdone, ovr, rle); end
        @(posedge clk); #1;
        rst = 1'b0;
        // Beats in IDLE must be ignored.
        for (int i = 0; i < 4; i++) begin
            shake = 1'b1; rdata = 32'h100 + i;
            @(posedge clk); #1;
            checks++;
            if (wea !== 1'b0) begin errors++; $display("FAIL idle_beat_wea got=%b want=0", wea); end
        end
        shake = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        nwr = 0;
        do_start(1'b1);
        run_beats(TOTAL, 0, 1'b0);
        do_stop(3'b100, "nominal");
    endtask

    task automatic test_gapped();
        nwr = 0;
        do_start(1'b0);
        run_beats(TOTAL, 3, 1'b0);
        do_stop(3'b100, "gapped");
    endtask

    task automatic test_overrun();
        nwr = 0;
        do_start(1'b0);
        run_beats(TOTAL + 4, 0, 1'b0);
        do_stop(3'b110, "overrun");
    endtask

    task automatic test_missing_rlast();
        nwr = 0;
        do_start(1'b0);
        run_beats(TOTAL, 0, 1'b1);
        do_stop(3'b101, "rlast");
    endtask

    task automatic test_abort();
        nwr = 0;
        do_start(1'b0);
        run_beats(101, 0, 1'b0);
        checks++;
        if (nwr !== 50) begin errors++; $display("FAIL abort_writes got=%0d want=50", nwr); end
        start = 1'b0;
        @(posedge clk); #1;
`ifdef AXI_RPACK_PARTIAL_FLUSH_EN
        checks++;
        if (wea !== 1'b1) begin errors++; $display("FAIL abort_flush_wea got=%b want=1", wea); end
        checks++;
        if (addra !== BRAM_AW'(50)) begin errors++; $display("FAIL abort_flush_addr got=%0d want=50", addra); end
        checks++;
        if (dina !== {32'h0, 32'd100}) begin errors++; $display("FAIL abort_flush_dina got=%h want=%h", dina, {32'h0, 32'd100}); end
`else
        checks++;
        if (wea !== 1'b0) begin errors++; $display("FAIL abort_nowrite_wea got=%b want=0", wea); end
`endif
        @(posedge clk); #1;
        checks++;
        if ({wea, wdone} !== 2'b00) begin errors++; $display("FAIL abort_after got=%b want=00", {wea, wdone}); end
    endtask

    task automatic test_reset_restart();
        nwr = 0;
        do_start(1'b0);
        run_beats(500, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wea, addra, dina, wdone, ovr, rle} !== '0)
            begin errors++; $display("FAIL async_reset got=%b/%h/%h/%b%b%b want=0", wea, addra, dina, wdone, ovr, rle); end
        @(posedge clk); #1;
        checks++;
        if (wea !== 1'b0) begin errors++; $display("FAIL reset_hold_wea got=%b want=0", wea); end
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        nwr = 0;
        do_start(1'b0);
        run_beats(TOTAL, 0, 1'b0);
        do_stop(3'b100, "restart");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_overrun();
        test_missing_rlast();
        test_abort();
        test_reset_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
